// File: rtl/cp0_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cp0_regfile                                                |
// | Brief    : MIPS coprocessor-0 register file, timer and interrupt flag |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module cp0_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        mtc0_we,
    input  logic [7:0]  c0_addr,
    input  logic [31:0] c0_wdata,
    input  logic        wb_ex,
    input  logic [13:0] ex_type,
    input  logic        wb_bd,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_badvaddr,
    input  logic        wb_eret,
    input  logic        exception_is_tlb_refill,
    input  logic [5:0]  ext_int_in,
    input  logic        is_TLBR,
    input  logic        is_TLBP,
    input  logic [77:0] TLB_rdata,
    input  logic        index_write_p,
    input  logic [3:0]  index_write_index,
    output logic [31:0] c0_rdata,
    output logic        has_int,
    output logic [31:0] cp0_index,
    output logic [31:0] cp0_entryhi,
    output logic [31:0] cp0_entrylo0,
    output logic [31:0] cp0_entrylo1,
    output logic [31:0] cp0_epc
);

    localparam logic [7:0] c_ADDR_INDEX    = 8'h00;
    localparam logic [7:0] c_ADDR_ENTRYLO0 = 8'h10;
    localparam logic [7:0] c_ADDR_ENTRYLO1 = 8'h18;
    localparam logic [7:0] c_ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] c_ADDR_COUNT    = 8'h48;
    localparam logic [7:0] c_ADDR_ENTRYHI  = 8'h50;
    localparam logic [7:0] c_ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] c_ADDR_STATUS   = 8'h60;
    localparam logic [7:0] c_ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] c_ADDR_EPC      = 8'h70;

    // Registered state
    logic        r_index_p_q,       w_index_p_d;
    logic [3:0]  r_index_q,         w_index_d;
    logic [25:0] r_entrylo0_q,      w_entrylo0_d;
    logic [25:0] r_entrylo1_q,      w_entrylo1_d;
    logic [31:0] r_badvaddr_q,      w_badvaddr_d;
    logic [31:0] r_count_q,         w_count_d;
    logic        r_tick_q,          w_tick_d;
    logic [18:0] r_entryhi_vpn2_q,  w_entryhi_vpn2_d;
    logic [7:0]  r_entryhi_asid_q,  w_entryhi_asid_d;
    logic [31:0] r_compare_q,       w_compare_d;
    logic [7:0]  r_status_im_q,     w_status_im_d;
    logic        r_status_exl_q,    w_status_exl_d;
    logic        r_status_ie_q,     w_status_ie_d;
    logic        r_cause_bd_q,      w_cause_bd_d;
    logic        r_cause_ti_q,      w_cause_ti_d;
    logic [5:0]  r_cause_iphw_q,    w_cause_iphw_d;
    logic [1:0]  r_cause_ipsw_q,    w_cause_ipsw_d;
    logic [4:0]  r_cause_exccode_q, w_cause_exccode_d;
    logic [31:0] r_epc_q,           w_epc_d;

    // Decode helpers
    logic        w_mtc0;
    logic        w_wr_index, w_wr_entrylo0, w_wr_entrylo1, w_wr_count;
    logic        w_wr_entryhi, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;
    logic [4:0]  w_exccode;
    logic        w_ex_loads_badv;
    logic        w_ex_loads_vpn2;
    logic [31:0] w_status_rd;
    logic [31:0] w_cause_rd;
    logic        w_unused_ok;

    assign w_unused_ok = exception_is_tlb_refill;

    assign w_mtc0        = mtc0_we & ~wb_ex & ~wb_eret;
    assign w_wr_index    = w_mtc0 & (c0_addr == c_ADDR_INDEX);
    assign w_wr_entrylo0 = w_mtc0 & (c0_addr == c_ADDR_ENTRYLO0);
    assign w_wr_entrylo1 = w_mtc0 & (c0_addr == c_ADDR_ENTRYLO1);
    assign w_wr_count    = w_mtc0 & (c0_addr == c_ADDR_COUNT);
    assign w_wr_entryhi  = w_mtc0 & (c0_addr == c_ADDR_ENTRYHI);
    assign w_wr_compare  = w_mtc0 & (c0_addr == c_ADDR_COMPARE);
    assign w_wr_status   = w_mtc0 & (c0_addr == c_ADDR_STATUS);
    assign w_wr_cause    = w_mtc0 & (c0_addr == c_ADDR_CAUSE);
    assign w_wr_epc      = w_mtc0 & (c0_addr == c_ADDR_EPC);

    function automatic logic [4:0] exc_code_of(input int bit_idx);
        case (bit_idx)
            1:       exc_code_of = 5'h04;
            2:       exc_code_of = 5'h02;
            3:       exc_code_of = 5'h0a;
            4:       exc_code_of = 5'h0c;
            5:       exc_code_of = 5'h08;
            6:       exc_code_of = 5'h09;
            7:       exc_code_of = 5'h04;
            8:       exc_code_of = 5'h05;
            9:       exc_code_of = 5'h02;
            10:      exc_code_of = 5'h03;
            11:      exc_code_of = 5'h01;
            default: exc_code_of = 5'h00;
        endcase
    endfunction

    // Scanning from the top down lets the lowest set bit have the final say.
    always_comb begin
        w_exccode       = 5'h00;
        w_ex_loads_badv = 1'b0;
        w_ex_loads_vpn2 = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (ex_type[i]) begin
                w_exccode       = exc_code_of(i);
                w_ex_loads_badv = (i == 1) || (i == 2) || ((i >= 7) && (i <= 11));
                w_ex_loads_vpn2 = (i == 2) || ((i >= 9) && (i <= 11));
            end
        end
    end

    always_comb begin
        w_index_p_d       = r_index_p_q;
        w_index_d         = r_index_q;
        w_entrylo0_d      = r_entrylo0_q;
        w_entrylo1_d      = r_entrylo1_q;
        w_badvaddr_d      = r_badvaddr_q;
        w_entryhi_vpn2_d  = r_entryhi_vpn2_q;
        w_entryhi_asid_d  = r_entryhi_asid_q;
        w_compare_d       = r_compare_q;
        w_status_im_d     = r_status_im_q;
        w_status_exl_d    = r_status_exl_q;
        w_status_ie_d     = r_status_ie_q;
        w_cause_bd_d      = r_cause_bd_q;
        w_cause_ipsw_d    = r_cause_ipsw_q;
        w_cause_exccode_d = r_cause_exccode_q;
        w_epc_d           = r_epc_q;

        if (w_wr_index) begin
            w_index_p_d = 1'b0;
            w_index_d   = c0_wdata[3:0];
        end
        if (w_wr_entrylo0) w_entrylo0_d = c0_wdata[25:0];
        if (w_wr_entrylo1) w_entrylo1_d = c0_wdata[25:0];
        if (w_wr_entryhi) begin
            w_entryhi_vpn2_d = c0_wdata[31:13];
            w_entryhi_asid_d = c0_wdata[7:0];
        end
        if (w_wr_compare) w_compare_d = c0_wdata;
        if (w_wr_status) begin
            w_status_im_d  = c0_wdata[15:8];
            w_status_exl_d = c0_wdata[1];
            w_status_ie_d  = c0_wdata[0];
        end
        if (w_wr_cause) w_cause_ipsw_d = c0_wdata[9:8];
        if (w_wr_epc)   w_epc_d        = c0_wdata;

        // TLB instructions are applied after MTC0 so they win on a shared target.
        if (is_TLBR) begin
            w_entryhi_vpn2_d = TLB_rdata[77:59];
            w_entryhi_asid_d = TLB_rdata[58:51];
            w_entrylo0_d     = {TLB_rdata[49:25], TLB_rdata[50]};
            w_entrylo1_d     = {TLB_rdata[24:0],  TLB_rdata[50]};
        end
        if (is_TLBP) begin
            w_index_p_d = index_write_p;
            w_index_d   = index_write_index;
        end

        if (wb_eret) w_status_exl_d = 1'b0;

        if (wb_ex) begin
            w_cause_exccode_d = w_exccode;
            if (!r_status_exl_q) begin
                w_epc_d      = wb_bd ? (wb_pc - 32'd4) : wb_pc;
                w_cause_bd_d = wb_bd;
            end
            w_status_exl_d = 1'b1;
            if (w_ex_loads_badv) w_badvaddr_d     = wb_badvaddr;
            if (w_ex_loads_vpn2) w_entryhi_vpn2_d = wb_badvaddr[31:13];
        end
    end

    // Timer and interrupt sampling
    always_comb begin
        w_tick_d  = ~r_tick_q;
        w_count_d = r_count_q + {31'b0, r_tick_q};
        if (w_wr_count) begin
            w_count_d = c0_wdata;
            w_tick_d  = 1'b0;
        end
        w_cause_ti_d = r_cause_ti_q | (r_count_q == r_compare_q);
        if (w_wr_compare) w_cause_ti_d = 1'b0;
        w_cause_iphw_d = {ext_int_in[5] | r_cause_ti_q, ext_int_in[4:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_index_p_q       <= 1'b0;
            r_index_q         <= 4'h0;
            r_entrylo0_q      <= 26'h0;
            r_entrylo1_q      <= 26'h0;
            r_badvaddr_q      <= 32'h0;
            r_count_q         <= 32'h0;
            r_tick_q          <= 1'b0;
            r_entryhi_vpn2_q  <= 19'h0;
            r_entryhi_asid_q  <= 8'h0;
            r_compare_q       <= 32'h0;
            r_status_im_q     <= 8'h0;
            r_status_exl_q    <= 1'b0;
            r_status_ie_q     <= 1'b0;
            r_cause_bd_q      <= 1'b0;
            r_cause_ti_q      <= 1'b0;
            r_cause_iphw_q    <= 6'h0;
            r_cause_ipsw_q    <= 2'h0;
            r_cause_exccode_q <= 5'h0;
            r_epc_q           <= 32'h0;
        end else begin
            r_index_p_q       <= w_index_p_d;
            r_index_q         <= w_index_d;
            r_entrylo0_q      <= w_entrylo0_d;
            r_entrylo1_q      <= w_entrylo1_d;
            r_badvaddr_q      <= w_badvaddr_d;
            r_count_q         <= w_count_d;
            r_tick_q          <= w_tick_d;
            r_entryhi_vpn2_q  <= w_entryhi_vpn2_d;
            r_entryhi_asid_q  <= w_entryhi_asid_d;
            r_compare_q       <= w_compare_d;
            r_status_im_q     <= w_status_im_d;
            r_status_exl_q    <= w_status_exl_d;
            r_status_ie_q     <= w_status_ie_d;
            r_cause_bd_q      <= w_cause_bd_d;
            r_cause_ti_q      <= w_cause_ti_d;
            r_cause_iphw_q    <= w_cause_iphw_d;
            r_cause_ipsw_q    <= w_cause_ipsw_d;
            r_cause_exccode_q <= w_cause_exccode_d;
            r_epc_q           <= w_epc_d;
        end
    end

    // BEV (bit 22) is hardwired high.
    assign w_status_rd = {9'b0, 1'b1, 6'b0, r_status_im_q, 6'b0, r_status_exl_q, r_status_ie_q};
    assign w_cause_rd  = {r_cause_bd_q, r_cause_ti_q, 14'b0, r_cause_iphw_q, r_cause_ipsw_q,
                          1'b0, r_cause_exccode_q, 2'b0};

    assign cp0_index    = {r_index_p_q, 27'b0, r_index_q};
    assign cp0_entryhi  = {r_entryhi_vpn2_q, 5'b0, r_entryhi_asid_q};
    assign cp0_entrylo0 = {6'b0, r_entrylo0_q};
    assign cp0_entrylo1 = {6'b0, r_entrylo1_q};
    assign cp0_epc      = r_epc_q;

    always_comb begin
        c0_rdata = 32'h0;
        case (c0_addr)
            c_ADDR_INDEX:    c0_rdata = cp0_index;
            c_ADDR_ENTRYLO0: c0_rdata = cp0_entrylo0;
            c_ADDR_ENTRYLO1: c0_rdata = cp0_entrylo1;
            c_ADDR_BADVADDR: c0_rdata = r_badvaddr_q;
            c_ADDR_COUNT:    c0_rdata = r_count_q;
            c_ADDR_ENTRYHI:  c0_rdata = cp0_entryhi;
            c_ADDR_COMPARE:  c0_rdata = r_compare_q;
            c_ADDR_STATUS:   c0_rdata = w_status_rd;
            c_ADDR_CAUSE:    c0_rdata = w_cause_rd;
            c_ADDR_EPC:      c0_rdata = r_epc_q;
            default:         c0_rdata = 32'h0;
        endcase
    end

    assign has_int = r_status_ie_q & ~r_status_exl_q &
                     (|({r_cause_iphw_q, r_cause_ipsw_q} & r_status_im_q));

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_cp0_regfile                                             |
// | Brief    : scoreboard bench for cp0_regfile with directed vectors     |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_cp0_regfile;

    localparam int c_SEL_RDATA  = 0;
    localparam int c_SEL_HASINT = 1;
    localparam int c_SEL_EPC    = 2;
    localparam int c_SEL_EHI    = 3;
    localparam int c_SEL_INDEX  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mtc0_we;
    logic [7:0]  c0_addr;
    logic [31:0] c0_wdata;
    logic        wb_ex;
    logic [13:0] ex_type;
    logic        wb_bd;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic        wb_eret;
    logic        exception_is_tlb_refill;
    logic [5:0]  ext_int_in;
    logic        is_TLBR;
    logic        is_TLBP;
    logic [77:0] TLB_rdata;
    logic        index_write_p;
    logic [3:0]  index_write_index;
    logic [31:0] c0_rdata;
    logic        has_int;
    logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_epc;

    cp0_regfile u_dut (
        .clk(clk), .reset(reset), .mtc0_we(mtc0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .wb_ex(wb_ex), .ex_type(ex_type), .wb_bd(wb_bd), .wb_pc(wb_pc),
        .wb_badvaddr(wb_badvaddr), .wb_eret(wb_eret),
        .exception_is_tlb_refill(exception_is_tlb_refill), .ext_int_in(ext_int_in),
        .is_TLBR(is_TLBR), .is_TLBP(is_TLBP), .TLB_rdata(TLB_rdata),
        .index_write_p(index_write_p), .index_write_index(index_write_index),
        .c0_rdata(c0_rdata), .has_int(has_int), .cp0_index(cp0_index),
        .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0),
        .cp0_entrylo1(cp0_entrylo1), .cp0_epc(cp0_epc)
    );

    always #5 clk = ~clk;

    // Scoreboard
    logic [31:0] q_exp[$];
    int          q_sel[$];
    string       q_name[$];
    logic        chk_valid = 1'b0;
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] mon_act;
    logic [31:0] mon_exp;
    int          mon_sel;
    string       mon_name;

    always @(negedge clk) begin
        if (chk_valid) begin
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: check strobe with no expected entry");
            end else begin
                mon_exp  = q_exp.pop_front();
                mon_sel  = q_sel.pop_front();
                mon_name = q_name.pop_front();
                case (mon_sel)
                    c_SEL_HASINT: mon_act = {31'b0, has_int};
                    c_SEL_EPC:    mon_act = cp0_epc;
                    c_SEL_EHI:    mon_act = cp0_entryhi;
                    c_SEL_INDEX:  mon_act = cp0_index;
                    default:      mon_act = c0_rdata;
                endcase
                n_vec++;
                if (mon_act !== mon_exp)
                    begin
                        n_fail++;
                        $display("FAIL %s: got %h expected %h", mon_name, mon_act, mon_exp);
                    end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string nm, input int sel, input logic [7:0] addr,
                              input logic [31:0] exp);
        c0_addr = addr;
        q_exp.push_back(exp);
        q_sel.push_back(sel);
        q_name.push_back(nm);
        chk_valid = 1'b1;
        step();
        chk_valid = 1'b0;
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
        mtc0_we  = 1'b1;
        c0_addr  = addr;
        c0_wdata = data;
        step();
        mtc0_we  = 1'b0;
    endtask

    task automatic raise_ex(input logic [13:0] et, input logic bd, input logic [31:0] pc,
                            input logic [31:0] badv);
        wb_ex       = 1'b1;
        ex_type     = et;
        wb_bd       = bd;
        wb_pc       = pc;
        wb_badvaddr = badv;
        step();
        wb_ex       = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mtc0_we = 1'b0; c0_addr = 8'h0; c0_wdata = 32'h0;
        wb_ex = 1'b0; ex_type = 14'h0; wb_bd = 1'b0; wb_pc = 32'h0; wb_badvaddr = 32'h0;
        wb_eret = 1'b0; exception_is_tlb_refill = 1'b0; ext_int_in = 6'h0;
        is_TLBR = 1'b0; is_TLBP = 1'b0; TLB_rdata = 78'h0;
        index_write_p = 1'b0; index_write_index = 4'h0;
        repeat (3) step();
        reset = 1'b0;

        // Reset values and free-running Count (one increment every two cycles)
        expect_val("status_reset", c_SEL_RDATA, 8'h60, 32'h0040_0000);
        expect_val("count_reset", c_SEL_RDATA, 8'h48, 32'h0);
        repeat (8) step();
        expect_val("count_after_10", c_SEL_RDATA, 8'h48, 32'd5);
        expect_val("unmapped_reads_0", c_SEL_RDATA, 8'h08, 32'h0);

        // Timer interrupt
        mtc0(8'h48, 32'h0);
        mtc0(8'h58, 32'd3);
        mtc0(8'h60, 32'h0000_8001);
        repeat (12) step();
        expect_val("timer_has_int", c_SEL_HASINT, 8'h00, 32'h1);
        expect_val("timer_cause", c_SEL_RDATA, 8'h68, 32'h4000_8000);
        mtc0(8'h58, 32'd3);
        step();
        expect_val("ti_cleared_has_int", c_SEL_HASINT, 8'h00, 32'h0);
        expect_val("ti_cleared_cause", c_SEL_RDATA, 8'h68, 32'h0);

        // Exception in a delay slot, then a nested one
        raise_ex(14'h0100, 1'b1, 32'hBFC0_0104, 32'h1);
        expect_val("ex1_epc", c_SEL_RDATA, 8'h70, 32'hBFC0_0100);
        expect_val("ex1_cause", c_SEL_RDATA, 8'h68, 32'h8000_0014);
        expect_val("ex1_badvaddr", c_SEL_RDATA, 8'h40, 32'h1);
        expect_val("ex1_status", c_SEL_RDATA, 8'h60, 32'h0040_8003);
        raise_ex(14'h0010, 1'b0, 32'h0000_1234, 32'h5555_0000);
        expect_val("ex2_epc_kept", c_SEL_EPC, 8'h00, 32'hBFC0_0100);
        expect_val("ex2_cause", c_SEL_RDATA, 8'h68, 32'h8000_0030);
        expect_val("ex2_badv_kept", c_SEL_RDATA, 8'h40, 32'h1);
        wb_eret = 1'b1;
        step();
        wb_eret = 1'b0;
        expect_val("eret_status", c_SEL_RDATA, 8'h60, 32'h0040_8001);

        // TLBR
        TLB_rdata = {19'h12345, 8'hAB, 1'b1, 20'h11111, 3'd2, 1'b1, 1'b1,
                     20'h22222, 3'd3, 1'b0, 1'b1};
        is_TLBR = 1'b1;
        step();
        is_TLBR = 1'b0;
        expect_val("tlbr_entryhi", c_SEL_RDATA, 8'h50, 32'h2468_A0AB);
        expect_val("tlbr_entrylo0", c_SEL_RDATA, 8'h10, 32'h0044_4457);
        expect_val("tlbr_entrylo1", c_SEL_RDATA, 8'h18, 32'h0088_889B);

        // TLBP then MTC0 Index
        index_write_p = 1'b1; index_write_index = 4'd5; is_TLBP = 1'b1;
        step();
        is_TLBP = 1'b0;
        expect_val("tlbp_index", c_SEL_INDEX, 8'h00, 32'h8000_0005);
        mtc0(8'h00, 32'd7);
        expect_val("mtc0_index", c_SEL_RDATA, 8'h00, 32'h0000_0007);

        // Exception beats a same-cycle MTC0 to EPC
        mtc0_we = 1'b1; c0_addr = 8'h70; c0_wdata = 32'hDEAD_BEEF;
        raise_ex(14'h0001, 1'b0, 32'h8000_1000, 32'h0);
        mtc0_we = 1'b0;
        expect_val("ex_beats_mtc0_epc", c_SEL_RDATA, 8'h70, 32'h8000_1000);
        mtc0(8'h68, 32'hFFFF_FFFF);
        expect_val("cause_write_mask", c_SEL_RDATA, 8'h68, 32'h0000_0300);

        // TLBS with EXL set: BadVAddr and EntryHi.VPN2 load, EPC untouched
        raise_ex(14'h0400, 1'b0, 32'h0000_2000, 32'hABCD_E123);
        expect_val("tlbs_badvaddr", c_SEL_RDATA, 8'h40, 32'hABCD_E123);
        expect_val("tlbs_entryhi", c_SEL_EHI, 8'h00, 32'hABCD_E0AB);
        expect_val("tlbs_cause", c_SEL_RDATA, 8'h68, 32'h0000_030C);
        expect_val("tlbs_epc_kept", c_SEL_EPC, 8'h00, 32'h8000_1000);

        // External interrupt level path
        wb_eret = 1'b1;
        step();
        wb_eret = 1'b0;
        mtc0(8'h60, 32'h0000_0401);
        expect_val("ext_int_idle", c_SEL_HASINT, 8'h00, 32'h0);
        ext_int_in = 6'b000001;
        step();
        step();
        expect_val("ext_int_has_int", c_SEL_HASINT, 8'h00, 32'h1);
        expect_val("ext_int_cause", c_SEL_RDATA, 8'h68, 32'h0000_070C);
        ext_int_in = 6'h0;

        // Count wraps to zero
        mtc0(8'h48, 32'hFFFF_FFFF);
        step();
        step();
        expect_val("count_wrap", c_SEL_RDATA, 8'h48, 32'h0);

        step();
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
